// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: opcodes, NOP word, opcode field and state encodings.
// Boot states only exist when RESET_VECTOR_EN is defined.
package fetch_stage_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;

  localparam logic [4:0]  OP_NOP   = 5'b00000;
  localparam logic [4:0]  OP_LDM   = 5'b10100;
  localparam logic [15:0] NOP_WORD = {OP_NOP, 11'h000};

`ifdef RESET_VECTOR_EN
  typedef enum logic [1:0] {
    BOOT_LO = 2'd0,
    BOOT_HI = 2'd1,
    RUN     = 2'd2,
    IMM     = 2'd3
  } state_t;
  localparam state_t RESET_STATE = BOOT_LO;
`else
  typedef enum logic [1:0] {
    RUN = 2'd2,
    IMM = 2'd3
  } state_t;
  localparam state_t RESET_STATE = RUN;
`endif

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter with hold, load and wrapping increment; priority rst > hold > load > increment.
// Updates on the clock edge; pc_inc is the combinational PC+1 used for the IF/ID tag.
module pc_register (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic [31:0] pc,
  output logic [31:0] pc_inc
);

  assign pc_inc = pc + 32'd1;

  always_ff @(posedge clk) begin
    if (rst)       pc <= 32'd0;
    else if (hold) pc <= pc;
    else if (load) pc <= load_value;
    else           pc <= pc_inc;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch FSM plus IF/ID register; one cycle from imem_addr to ifid_instr, stall holds everything.
// RESET_VECTOR_EN adds two boot cycles that load the start PC from words 0 and 1.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        ifid_imm
);

  state_t      state, state_nx;
  logic [31:0] pc, pc_inc;
  logic        pc_hold, pc_load;
  logic [31:0] pc_load_value;
  logic        fetch_en, nop_en;

  pc_register u_pc (
    .clk        (clk),
    .rst        (rst),
    .hold       (pc_hold),
    .load       (pc_load),
    .load_value (pc_load_value),
    .pc         (pc),
    .pc_inc     (pc_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    imem_addr     = pc;
    pc_hold       = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = branch_target;
    fetch_en      = 1'b0;
    nop_en        = 1'b0;
    case (state)
`ifdef RESET_VECTOR_EN
      // Boot cycles ignore stall/flush/branch and keep IF/ID empty.
      BOOT_LO: begin
        imem_addr     = 32'd0;
        pc_load       = 1'b1;
        pc_load_value = {pc[31:16], imem_data};
        nop_en        = 1'b1;
        state_nx      = BOOT_HI;
      end
      BOOT_HI: begin
        imem_addr     = 32'd1;
        pc_load       = 1'b1;
        pc_load_value = {imem_data, pc[15:0]};
        nop_en        = 1'b1;
        state_nx      = RUN;
      end
`endif
      default: begin
        if (stall) begin
          pc_hold = 1'b1;
        end else if (branch_taken) begin
          pc_load  = 1'b1;
          nop_en   = 1'b1;
          state_nx = RUN;
        end else if (flush) begin
          nop_en   = 1'b1;
          state_nx = RUN;
        end else begin
          fetch_en = 1'b1;
          // The word after an LDM is its immediate, never an opcode.
          if (state == IMM)                              state_nx = RUN;
          else if (imem_data[OPC_HI:OPC_LO] == OP_LDM)   state_nx = IMM;
          else                                           state_nx = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || nop_en) begin
      ifid_instr <= NOP_WORD;
      ifid_pc    <= 32'd0;
      ifid_valid <= 1'b0;
      ifid_imm   <= 1'b0;
    end else if (fetch_en) begin
      ifid_instr <= imem_data;
      ifid_pc    <= pc_inc;
      ifid_valid <= 1'b1;
      ifid_imm   <= (state == IMM);
    end
  end

endmodule
